// File: rtl/lives_hearts_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lives_hearts_ctrl                                            |
// | Description : HUD lives controller feeding the 16x16 heart bitmap.         |
// |               Keeps the lives count and the post-hit invulnerability       |
// |               window. Maps the VGA scan position onto a row of heart       |
// |               slots and produces registered offsetX/offsetY/               |
// |               InsideRectangle for every owned heart. All hearts blink      |
// |               while invulnerable. gameOver is flagged at zero lives.       |
// | Option      : `define LIVES_EMPTY_SLOT_EN to drive slotEmpty and the       |
// |               offsets for slots whose life has been lost. Without it,      |
// |               slotEmpty is tied low.                                       |
// | Ports       : clk             pixel clock                                  |
// |               resetN          asynchronous active-low reset                |
// |               startOfFrame    one-cycle pulse per frame                    |
// |               pixelX/pixelY   current scan position (11 bit)               |
// |               hit             collision pulse                              |
// |               extraLife       bonus pulse                                  |
// |               newGame         restart pulse                                |
// |               offsetX/offsetY offset inside the current heart              |
// |               InsideRectangle pixel lies in a visible heart                |
// |               lives           current lives count                          |
// |               invulnerable    invulnerability window active                |
// |               gameOver        lives reached zero                           |
// |               slotEmpty       pixel lies in a lost-life slot               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module lives_hearts_ctrl #(
   parameter int TOP_LEFT_X    = 16,
   parameter int TOP_LEFT_Y    = 8,
   parameter int HEART_SIZE    = 16,
   parameter int SPACING       = 20,
   parameter int MAX_LIVES     = 5,
   parameter int START_LIVES   = 3,
   parameter int INVULN_FRAMES = 60,
   parameter int BLINK_FRAMES  = 8
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        startOfFrame,
   input  logic [10:0] pixelX,
   input  logic [10:0] pixelY,
   input  logic        hit,
   input  logic        extraLife,
   input  logic        newGame,
   output logic [10:0] offsetX,
   output logic [10:0] offsetY,
   output logic        InsideRectangle,
   output logic [2:0]  lives,
   output logic        invulnerable,
   output logic        gameOver,
   output logic        slotEmpty
);

   // -------------------------------------------------------------------------
   // Constants
   // -------------------------------------------------------------------------
   localparam int INV_W = (INVULN_FRAMES > 0) ? $clog2(INVULN_FRAMES + 1) : 1;
   localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [INV_W-1:0] INV_LOAD   = INV_W'(INVULN_FRAMES);
   localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_FRAMES - 1);
   localparam logic [2:0]       START_VAL  = 3'(START_LIVES);
   localparam logic [2:0]       MAX_VAL    = 3'(MAX_LIVES);
   localparam logic [10:0]      ROW_Y0     = 11'(TOP_LEFT_Y);
   localparam logic [10:0]      ROW_Y1     = 11'(TOP_LEFT_Y + HEART_SIZE - 1);

   // -------------------------------------------------------------------------
   // Game state
   // -------------------------------------------------------------------------
   logic [2:0]       lives_q,        lives_d;
   logic [INV_W-1:0] invuln_cnt_q,   invuln_cnt_d;
   logic [BLK_W-1:0] blink_cnt_q,    blink_cnt_d;
   logic             phase_q,        phase_d;
   logic             game_over_q,    game_over_d;
   logic             invulnerable_q, invulnerable_d;

   logic             hit_acc;
   logic             extra_acc;

   always_comb begin
      lives_d     = lives_q;
      invuln_cnt_d = invuln_cnt_q;
      blink_cnt_d = blink_cnt_q;
      phase_d     = phase_q;
      game_over_d = game_over_q;
      hit_acc     = 1'b0;
      extra_acc   = 1'b0;

      if (newGame) begin
         // Synchronous equivalent of reset; hit/extraLife are dropped.
         lives_d      = START_VAL;
         invuln_cnt_d = '0;
         blink_cnt_d  = '0;
         phase_d      = 1'b0;
         game_over_d  = 1'b0;
      end else begin
         // A zero lives count implies gameOver, so the lives check alone
         // also blocks hits after game over.
         hit_acc   = hit && (lives_q != 3'd0) && !invulnerable_q;
         extra_acc = extraLife && !hit_acc && !game_over_q;

         if (hit_acc) begin
            // Reload takes precedence over a coincident frame tick.
            lives_d      = lives_q - 3'd1;
            invuln_cnt_d = INV_LOAD;
            blink_cnt_d  = '0;
            phase_d      = 1'b0;
            if (lives_q == 3'd1) begin
               game_over_d = 1'b1;
            end
         end else if (startOfFrame && (invuln_cnt_q != '0)) begin
            invuln_cnt_d = invuln_cnt_q - 1'b1;
            if (blink_cnt_q == BLINK_LAST) begin
               blink_cnt_d = '0;
               phase_d     = ~phase_q;
            end else begin
               blink_cnt_d = blink_cnt_q + 1'b1;
            end
         end

         if (extra_acc && (lives_q < MAX_VAL)) begin
            lives_d = lives_q + 3'd1;
         end

         // Leaving the window always lands on the visible half of the blink.
         if (invuln_cnt_d == '0) begin
            phase_d     = 1'b0;
            blink_cnt_d = '0;
         end
      end

      invulnerable_d = (invuln_cnt_d != '0);
   end

   // -------------------------------------------------------------------------
   // Slot geometry: one comparator pair per slot against elaborated bounds.
   // The next-state lives/phase are used so that an event is visible in the
   // geometry outputs from the cycle right after it.
   // -------------------------------------------------------------------------
   logic                 row_hit;
   logic [MAX_LIVES-1:0] in_slot;
   logic [MAX_LIVES-1:0] owned;
   logic [MAX_LIVES-1:0] show_heart;
   logic [MAX_LIVES-1:0] use_off;
   logic [10:0]          slot_off_x [MAX_LIVES];

   assign row_hit = (pixelY >= ROW_Y0) && (pixelY <= ROW_Y1);

   generate
      for (genvar i = 0; i < MAX_LIVES; i++) begin : g_slot
         localparam logic [10:0] ORG_X = 11'(TOP_LEFT_X + i * SPACING);
         localparam logic [10:0] END_X = 11'(TOP_LEFT_X + i * SPACING + HEART_SIZE - 1);
         localparam logic [2:0]  IDX   = 3'(i);

         assign in_slot[i]    = row_hit && (pixelX >= ORG_X) && (pixelX <= END_X);
         assign owned[i]      = (IDX < lives_d);
         assign slot_off_x[i] = pixelX - ORG_X;
      end
   endgenerate

   assign show_heart = in_slot & owned & {MAX_LIVES{~phase_d}};

`ifdef LIVES_EMPTY_SLOT_EN
   logic [MAX_LIVES-1:0] show_empty;
   logic                 slot_empty_q, slot_empty_d;

   // Lost-life slots are outlined regardless of blink phase.
   assign show_empty   = in_slot & ~owned;
   assign use_off      = show_heart | show_empty;
   assign slot_empty_d = |show_empty;
`else
   assign use_off = show_heart;
`endif

   logic        inside_q,   inside_d;
   logic [10:0] offset_x_q, offset_x_d;
   logic [10:0] offset_y_q, offset_y_d;

   // Slots never overlap, so at most one bit of use_off is set.
   always_comb begin
      inside_d   = |show_heart;
      offset_x_d = '0;
      for (int i = 0; i < MAX_LIVES; i++) begin
         if (use_off[i]) begin
            offset_x_d = slot_off_x[i];
         end
      end
      offset_y_d = (|use_off) ? (pixelY - ROW_Y0) : 11'd0;
   end

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         lives_q        <= START_VAL;
         invuln_cnt_q   <= '0;
         blink_cnt_q    <= '0;
         phase_q        <= 1'b0;
         game_over_q    <= 1'b0;
         invulnerable_q <= 1'b0;
         inside_q       <= 1'b0;
         offset_x_q     <= '0;
         offset_y_q     <= '0;
      end else begin
         lives_q        <= lives_d;
         invuln_cnt_q   <= invuln_cnt_d;
         blink_cnt_q    <= blink_cnt_d;
         phase_q        <= phase_d;
         game_over_q    <= game_over_d;
         invulnerable_q <= invulnerable_d;
         inside_q       <= inside_d;
         offset_x_q     <= offset_x_d;
         offset_y_q     <= offset_y_d;
      end
   end

`ifdef LIVES_EMPTY_SLOT_EN
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         slot_empty_q <= 1'b0;
      end else begin
         slot_empty_q <= slot_empty_d;
      end
   end

   assign slotEmpty = slot_empty_q;
`else
   assign slotEmpty = 1'b0;
`endif

   assign lives           = lives_q;
   assign invulnerable    = invulnerable_q;
   assign gameOver        = game_over_q;
   assign InsideRectangle = inside_q;
   assign offsetX         = offset_x_q;
   assign offsetY         = offset_y_q;

endmodule
`default_nettype wire

// File: tb/tb_lives_hearts_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_lives_hearts_ctrl                                         |
// | Description : Self-checking bench for lives_hearts_ctrl. A behavioural     |
// |               model tracks lives, frames left in the invulnerability       |
// |               window and frames elapsed since the hit. Slot geometry is    |
// |               computed arithmetically from the pixel position.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_lives_hearts_ctrl;

   localparam int TLX   = 16;
   localparam int TLY   = 8;
   localparam int HS    = 16;
   localparam int SP    = 20;
   localparam int MAXL  = 5;
   localparam int START = 3;
   localparam int INV   = 60;
   localparam int BLINK = 8;

   logic        clk = 1'b0;
   logic        resetN = 1'b1;
   logic        startOfFrame = 1'b0;
   logic [10:0] pixelX = '0;
   logic [10:0] pixelY = '0;
   logic        hit = 1'b0;
   logic        extraLife = 1'b0;
   logic        newGame = 1'b0;
   logic [10:0] offsetX;
   logic [10:0] offsetY;
   logic        InsideRectangle;
   logic [2:0]  lives;
   logic        invulnerable;
   logic        gameOver;
   logic        slotEmpty;

   int ntests = 0;
   int nfails = 0;

   always #5 clk = ~clk;

   lives_hearts_ctrl #(
      .TOP_LEFT_X   (TLX),
      .TOP_LEFT_Y   (TLY),
      .HEART_SIZE   (HS),
      .SPACING      (SP),
      .MAX_LIVES    (MAXL),
      .START_LIVES  (START),
      .INVULN_FRAMES(INV),
      .BLINK_FRAMES (BLINK)
   ) dut (
      .clk            (clk),
      .resetN         (resetN),
      .startOfFrame   (startOfFrame),
      .pixelX         (pixelX),
      .pixelY         (pixelY),
      .hit            (hit),
      .extraLife      (extraLife),
      .newGame        (newGame),
      .offsetX        (offsetX),
      .offsetY        (offsetY),
      .InsideRectangle(InsideRectangle),
      .lives          (lives),
      .invulnerable   (invulnerable),
      .gameOver       (gameOver),
      .slotEmpty      (slotEmpty)
   );

   // ---------------------------------------------------------------------
   // Behavioural model
   // ---------------------------------------------------------------------
   typedef struct {
      int lives;
      int inv;    // frames left in the window
      int f;      // frames elapsed since the last accepted hit
      int go;
      int ins;
      int ox;
      int oy;
      int se;
   } mst_t;

   function automatic mst_t m_reset();
      mst_t r;
      r.lives = START; r.inv = 0; r.f = 0; r.go = 0;
      r.ins = 0; r.ox = 0; r.oy = 0; r.se = 0;
      return r;
   endfunction

   function automatic mst_t m_next(mst_t s, int x, int y, bit sof, bit h, bit e, bit ng);
      mst_t r;
      bit   acc;
      bit   in;
      int   slot;
      int   rel;
      int   ph;
      r = s;
      if (ng) begin
         r = m_reset();
      end else begin
         acc = h && (s.lives > 0) && (s.inv == 0);
         if (acc) begin
            r.lives = s.lives - 1;
            r.inv   = INV;
            r.f     = 0;
            if (r.lives == 0) r.go = 1;
         end else if (sof && s.inv > 0) begin
            r.inv = s.inv - 1;
            r.f   = s.f + 1;
         end
         if (e && !acc && (s.go == 0) && (r.lives < MAXL)) r.lives = r.lives + 1;
      end
      ph   = (r.inv > 0) ? ((r.f / BLINK) % 2) : 0;
      in   = 1'b0;
      slot = 0;
      rel  = 0;
      if (y >= TLY && y < TLY + HS && x >= TLX) begin
         slot = (x - TLX) / SP;
         rel  = (x - TLX) % SP;
         in   = (slot < MAXL) && (rel < HS);
      end
      r.ins = (in && slot < r.lives && ph == 0) ? 1 : 0;
      r.se  = 0;
`ifdef LIVES_EMPTY_SLOT_EN
      r.se  = (in && slot >= r.lives) ? 1 : 0;
`endif
      r.ox  = 0;
      r.oy  = 0;
      if (r.ins != 0 || r.se != 0) begin
         r.ox = rel;
         r.oy = y - TLY;
      end
      return r;
   endfunction

   mst_t m;

   always @(posedge clk or negedge resetN) begin
      if (!resetN) m <= m_reset();
      else         m <= m_next(m, int'(pixelX), int'(pixelY), startOfFrame, hit, extraLife, newGame);
   end

   // ---------------------------------------------------------------------
   // Checking helpers
   // ---------------------------------------------------------------------
   task automatic chk(input string name, input int act, input int exp);
      ntests++;
      if (act != exp) begin
         nfails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cmp_model();
      chk("m_lives",   int'(lives),           m.lives);
      chk("m_invuln",  int'(invulnerable),    (m.inv > 0) ? 1 : 0);
      chk("m_gameover",int'(gameOver),        m.go);
      chk("m_inside",  int'(InsideRectangle), m.ins);
      chk("m_offx",    int'(offsetX),         m.ox);
      chk("m_offy",    int'(offsetY),         m.oy);
      chk("m_empty",   int'(slotEmpty),       m.se);
   endtask

   // One clock: inputs applied on the falling edge, outputs checked 1 time
   // unit after the rising edge that captures them.
   task automatic tick(input int x, input int y, input bit s, input bit h, input bit e, input bit n);
      @(negedge clk);
      pixelX       = 11'(x);
      pixelY       = 11'(y);
      startOfFrame = s;
      hit          = h;
      extraLife    = e;
      newGame      = n;
      @(posedge clk);
      #1;
      startOfFrame = 1'b0;
      hit          = 1'b0;
      extraLife    = 1'b0;
      newGame      = 1'b0;
      cmp_model();
   endtask

   // ---------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------
   initial begin
      #1 resetN = 1'b0;
      #2;
      chk("rst_lives",  int'(lives), 3);
      chk("rst_inside", int'(InsideRectangle), 0);
      chk("rst_go",     int'(gameOver), 0);
      chk("rst_inv",    int'(invulnerable), 0);
      chk("rst_offx",   int'(offsetX), 0);
      chk("rst_offy",   int'(offsetY), 0);
      chk("rst_empty",  int'(slotEmpty), 0);
      @(negedge clk);
      @(negedge clk);
      resetN = 1'b1;

      // Geometry after reset
      tick(16, 8, 0, 0, 0, 0);
      chk("g0_inside", int'(InsideRectangle), 1);
      chk("g0_offx",   int'(offsetX), 0);
      chk("g0_offy",   int'(offsetY), 0);
      chk("g0_lives",  int'(lives), 3);
      tick(51, 23, 0, 0, 0, 0);
      chk("g1_inside", int'(InsideRectangle), 1);
      chk("g1_offx",   int'(offsetX), 15);
      chk("g1_offy",   int'(offsetY), 15);
      tick(76, 8, 0, 0, 0, 0);
      chk("g3_inside", int'(InsideRectangle), 0);

      // Hit, ignored second hit, blinking, expiry
      tick(16, 8, 0, 1, 0, 0);
      chk("hit_lives", int'(lives), 2);
      chk("hit_inv",   int'(invulnerable), 1);
      chk("blink_f0",  int'(InsideRectangle), 1);
      for (int k = 1; k <= 60; k++) begin
         tick(16, 8, 1, 0, 0, 0);
         if (k == 5) begin
            tick(16, 8, 0, 1, 0, 0);
            chk("hit2_ignored", int'(lives), 2);
         end
         if (k == 7)  chk("blink_f7",  int'(InsideRectangle), 1);
         if (k == 8)  chk("blink_f8",  int'(InsideRectangle), 0);
         if (k == 15) chk("blink_f15", int'(InsideRectangle), 0);
         if (k == 16) chk("blink_f16", int'(InsideRectangle), 1);
         if (k == 23) chk("blink_f23", int'(InsideRectangle), 1);
         if (k == 59) chk("inv_f59",   int'(invulnerable), 1);
      end
      chk("inv_expired", int'(invulnerable), 0);
      chk("vis_after",   int'(InsideRectangle), 1);

      // Extra lives saturate at MAX_LIVES
      tick(96, 8, 0, 0, 0, 1);
      chk("ng_lives", int'(lives), 3);
      for (int k = 0; k < 5; k++) tick(96, 8, 0, 0, 1, 0);
      chk("sat_lives", int'(lives), 5);
      tick(96, 8, 0, 0, 0, 0);
      chk("g4_inside", int'(InsideRectangle), 1);
      chk("g4_offx",   int'(offsetX), 0);
      chk("g4_offy",   int'(offsetY), 0);

      // Run down to game over
      tick(0, 0, 0, 0, 0, 1);
      for (int n = 0; n < 3; n++) begin
         tick(0, 0, 0, 1, 0, 0);
         for (int k = 0; k < 60; k++) tick(0, 0, 1, 0, 0, 0);
      end
      chk("go_lives", int'(lives), 0);
      chk("go_flag",  int'(gameOver), 1);
      tick(16, 8, 0, 0, 1, 0);
      chk("go_extra_lives", int'(lives), 0);
      chk("go_no_heart",    int'(InsideRectangle), 0);
      tick(0, 0, 0, 0, 0, 1);
      chk("ng2_lives", int'(lives), 3);
      chk("ng2_go",    int'(gameOver), 0);
      chk("ng2_inv",   int'(invulnerable), 0);

      // Coincident events
      tick(0, 0, 0, 1, 1, 0);
      chk("hit_extra_lives", int'(lives), 2);
      tick(0, 0, 0, 1, 0, 1);
      chk("ng_hit_lives", int'(lives), 3);
      chk("ng_hit_inv",   int'(invulnerable), 0);
      tick(80, 10, 0, 0, 0, 0);
      chk("empty_inside", int'(InsideRectangle), 0);
`ifdef LIVES_EMPTY_SLOT_EN
      chk("empty_flag", int'(slotEmpty), 1);
      chk("empty_offx", int'(offsetX), 4);
      chk("empty_offy", int'(offsetY), 2);
`else
      chk("empty_flag", int'(slotEmpty), 0);
      chk("empty_offx", int'(offsetX), 0);
      chk("empty_offy", int'(offsetY), 0);
`endif

      // Randomized traffic against the model
      for (int k = 0; k < 4000; k++) begin
         tick($urandom_range(0, 130), $urandom_range(0, 31),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 15) == 0), ($urandom_range(0, 299) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", ntests, nfails);
      $finish;
   end

endmodule
`default_nettype wire
